// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, FSM states and default error vector for pipe_ctrl
package pipe_ctrl_pkg;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MDU     = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;
    localparam logic [31:0] ERR_VEC_DEFAULT = 32'hBFC0_0380;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with MDU sequencing and bus-wait watchdog
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          MDU_LAT     = 32,
    parameter int          MEM_TIMEOUT = 64,
    parameter logic [31:0] ERR_VEC     = ERR_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stallreq,
    input  logic        ex_mdu_start,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        flush_req,
    input  logic [31:0] exc_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mdu_done,
    output logic        bus_err
);
    localparam int CW = $clog2(MDU_LAT) + 1;
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    logic [1:0]    state_q, state_d;
    logic          ret_mdu_q, ret_mdu_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          mem_wait, timeout;
    assign mem_wait = mem_req & ~mem_ack;
    assign timeout  = (state_q == ST_MEMWAIT) && (wcnt_q == WW'(MEM_TIMEOUT - 1)) && !mem_ack;
    always_comb begin
        stall     = STALL_NONE;
        flush     = 1'b0;
        new_pc    = '0;
        mdu_done  = 1'b0;
        bus_err   = 1'b0;
        state_d   = state_q;
        ret_mdu_d = ret_mdu_q;
        cnt_d     = cnt_q;
        wcnt_d    = '0;
        if (flush_req) begin
            flush     = 1'b1;
            new_pc    = exc_pc;
            state_d   = ST_RUN;
            ret_mdu_d = 1'b0;
            cnt_d     = '0;
        end else if (timeout) begin
            bus_err   = 1'b1;
            flush     = 1'b1;
            new_pc    = ERR_VEC;
            state_d   = ST_RUN;
            ret_mdu_d = 1'b0;
            cnt_d     = '0;
        end else if (mem_wait) begin
            // the MDU counter is left untouched so the op resumes where it paused
            stall  = STALL_MEM;
            wcnt_d = wcnt_q + WW'(1);
            if (state_q != ST_MEMWAIT) begin
                ret_mdu_d = (state_q == ST_MDU);
                state_d   = ST_MEMWAIT;
            end
        end else if (state_q == ST_MEMWAIT) begin
            state_d = ret_mdu_q ? ST_MDU : ST_RUN;
        end else if (state_q == ST_MDU) begin
            stall    = (cnt_q != '0) ? STALL_EX : STALL_NONE;
            mdu_done = (cnt_q == '0);
            cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
            state_d  = (cnt_q != '0) ? ST_MDU : ST_RUN;
        end else if (ex_mdu_start) begin
            stall   = STALL_EX;
            cnt_d   = CW'(MDU_LAT - 1);
            state_d = ST_MDU;
        end else if (id_stallreq) begin
            stall = STALL_ID;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            ret_mdu_q <= 1'b0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ret_mdu_q <= ret_mdu_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random checks of pipe_ctrl against a cycle-budget reference model
module tb_pipe_ctrl;
    localparam int          LAT = 32;
    localparam int          TO  = 64;
    localparam logic [31:0] EV  = 32'hBFC0_0380;
    localparam logic [5:0]  S_ID  = 6'b000111;
    localparam logic [5:0]  S_EX  = 6'b001111;
    localparam logic [5:0]  S_MEM = 6'b011111;
    logic        clk = 1'b0;
    logic        rst, id_stallreq, ex_mdu_start, mem_req, mem_ack, flush_req;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        flush, mdu_done, bus_err;
    logic [31:0] new_pc;
    int total = 0;
    int bad = 0;
    // model: an MDU op owes `left` more EX-hold cycles; `waits` counts consecutive bus waits
    bit busy = 0;
    int left = 0;
    int waits = 0;
    logic [5:0]  e_stall, s_stall;
    logic        e_flush, e_done, e_err, s_flush, s_done, s_err;
    logic [31:0] e_pc, s_pc;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_mdu_start(ex_mdu_start),
        .mem_req(mem_req), .mem_ack(mem_ack), .flush_req(flush_req), .exc_pc(exc_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .mdu_done(mdu_done), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model();
        e_stall = 6'b0; e_flush = 0; e_pc = 32'h0; e_done = 0; e_err = 0;
        if (flush_req) begin
            e_flush = 1; e_pc = exc_pc; busy = 0; waits = 0;
        end else if (waits == TO - 1 && !mem_ack) begin
            e_flush = 1; e_err = 1; e_pc = EV; busy = 0; waits = 0;
        end else if (mem_req && !mem_ack) begin
            e_stall = S_MEM; waits++;
        end else if (waits > 0) begin
            waits = 0;
        end else if (busy) begin
            if (left > 0) begin
                e_stall = S_EX; left--;
            end else begin
                e_done = 1; busy = 0;
            end
        end else if (ex_mdu_start) begin
            e_stall = S_EX; busy = 1; left = LAT - 1;
        end else if (id_stallreq) begin
            e_stall = S_ID;
        end
        if (rst) begin
            busy = 0; waits = 0;
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        s_stall = stall; s_flush = flush; s_pc = new_pc; s_done = mdu_done; s_err = bus_err;
        model();
        chk(tag, {25'd0, s_stall, s_flush, s_pc, s_done, s_err},
                 {25'd0, e_stall, e_flush, e_pc, e_done, e_err});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; id_stallreq = 0; ex_mdu_start = 0; mem_req = 0; mem_ack = 0;
        flush_req = 0; exc_pc = 32'h0;
    endtask

    initial begin
        int n, hold, k, dones;
        idle();
        rst = 1;
        cyc("reset");
        cyc("reset");
        rst = 0;
        cyc("idle");
        chk("reset_outputs", {s_stall, s_flush, s_pc, s_done, s_err}, 64'd0);

        id_stallreq = 1;
        cyc("loaduse1");
        chk("loaduse1_stall", s_stall, S_ID);
        cyc("loaduse2");
        chk("loaduse2_stall", s_stall, S_ID);
        id_stallreq = 0;
        cyc("loaduse_end");
        chk("loaduse_end_stall", s_stall, 6'b0);

        ex_mdu_start = 1; n = 0; hold = 0;
        do begin
            cyc("mdu");
            ex_mdu_start = 0;
            n++;
            if (s_stall === S_EX) hold++;
        end while (!s_done && n < 40);
        chk("mdu_done_cycle", n, 33);
        chk("mdu_hold_cycles", hold, 32);
        chk("mdu_done_stall", s_stall, 6'b0);

        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            cyc("memwait");
            chk("memwait_stall", s_stall, S_MEM);
        end
        mem_ack = 1;
        cyc("memack");
        chk("memack_stall", s_stall, 6'b0);
        idle();
        id_stallreq = 1;
        cyc("after_mem_run");
        chk("after_mem_run_stall", s_stall, S_ID);
        id_stallreq = 0;

        n = -1;
        for (int t = 0; t < 45 && n < 0; t++) begin
            idle();
            ex_mdu_start = (t == 0);
            mem_req = (t >= 5 && t <= 9);
            mem_ack = (t == 9);
            cyc("mdu_wait");
            if (s_done) n = t;
        end
        chk("mdu_wait_done_t", n, 37);

        idle();
        mem_req = 1; k = 0;
        do begin
            cyc("timeout");
            k++;
        end while (!s_err && k < 70);
        chk("timeout_cycle", k, TO);
        chk("timeout_pc", {s_flush, s_stall, s_pc}, {1'b1, 6'b0, EV});
        mem_req = 0;
        cyc("after_timeout");
        chk("after_timeout_quiet", {s_flush, s_err, s_stall}, 8'd0);

        dones = 0;
        for (int t = 0; t < 45; t++) begin
            idle();
            ex_mdu_start = (t == 0);
            flush_req = (t == 10);
            exc_pc = (t == 10) ? 32'h8000_0180 : 32'h0;
            cyc("mdu_flush");
            if (t == 10) chk("flush_out", {s_flush, s_stall, s_pc}, {1'b1, 6'b0, 32'h8000_0180});
            if (s_done) dones++;
        end
        chk("flush_no_done", dones, 0);

        for (int t = 0; t < 6; t++) begin
            idle();
            ex_mdu_start = (t == 0);
            rst = (t == 5);
            cyc("mdu_reset");
        end
        idle();
        cyc("post_reset");
        chk("post_reset_outputs", {s_stall, s_flush, s_pc, s_done, s_err}, 64'd0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush_req = ($urandom_range(0, 79) == 0);
            exc_pc = $urandom;
            id_stallreq = $urandom_range(0, 3) == 0;
            ex_mdu_start = $urandom_range(0, 9) == 0;
            if (waits > 0 && $urandom_range(0, 9) < 8) mem_req = 1;
            else mem_req = $urandom_range(0, 5) == 0;
            mem_ack = $urandom_range(0, 3) == 0;
            cyc("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage MIPS32 pipeline. It collects hazard requests from ID (load-use), EX (multi-cycle mult/div), MEM (data-bus wait) and the exception unit. It drives one stall vector to the PC and every inter-stage register (if_id, id_ex, ex_mem, mem_wb), plus a flush pulse with redirect PC. It sequences multi-cycle EX operations with a down-counter and guards the data bus with a wait-timeout watchdog.

## Interface
- MDU_LAT, 32, cycles EX is held for a multi-cycle op (≥1)
- MEM_TIMEOUT, 64, max consecutive wait cycles before bus error (≥2)
- ERR_VEC, 32'hBFC0_0380, redirect PC on bus-timeout error
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_stallreq  in  1  load-use hazard in ID
- ex_mdu_start  in  1  EX holds a multi-cycle op, first cycle
- mem_req  in  1  MEM stage has a data access outstanding
- mem_ack  in  1  data bus completes access this cycle
- flush_req  in  1  exception committed in MEM
- exc_pc  in  32  handler address for flush_req
- stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush=1
- mdu_done  out  1  multi-cycle result valid, EX advances
- bus_err  out  1  one-cycle pulse on MEM timeout

## Operation
- States: RUN, MDU, MEMWAIT. State, MDU counter and wait counter are registered. stall/flush/new_pc/mdu_done/bus_err are combinational from state + inputs.
- Priority each cycle: flush_req > timeout > mem wait > MDU > id_stallreq. The highest active source alone sets the outputs.
- flush_req=1: flush=1, new_pc=exc_pc, stall=000000. Next state RUN, both counters cleared, MDU op aborted (no mdu_done).
- Timeout: in MEMWAIT with wait count == MEM_TIMEOUT-1 and mem_ack=0. Outputs bus_err=1, flush=1, new_pc=ERR_VEC, stall=000000. Next state RUN, counters cleared.
- Mem wait: mem_req=1 and mem_ack=0 gives stall=011111. From RUN or MDU, go to MEMWAIT and wcnt counts up from 0. In MEMWAIT, mem_ack=1 gives stall=000000 and a return to the saved state (RUN, or MDU with its counter intact).
- MDU start: in RUN, ex_mdu_start=1 with no higher request gives stall=001111, cnt<=MDU_LAT-1, next MDU.
- In MDU with cnt≠0: stall=001111, cnt decrements. The counter freezes while a mem wait is active.
- In MDU with cnt==0 and no mem wait: mdu_done=1, stall=000000, next RUN. ex_mdu_start is ignored in MDU state.
- id_stallreq, when it is the only request: stall=000111 for that cycle; no state change.
- Counters: cnt width $clog2(MDU_LAT)+1, wcnt width $clog2(MEM_TIMEOUT)+1. Unsigned, no wrap.

## Timing
- Reset: state RUN, cnt=0, wcnt=0. stall=000000, flush=0, new_pc=0, mdu_done=0, bus_err=0 while idle.
- Reset mid-MDU or mid-MEMWAIT aborts the operation the next edge; no mdu_done, no bus_err.
- Load-use: 1 stall cycle per cycle id_stallreq is held; zero-latency combinational response.
- MDU: EX held exactly MDU_LAT cycles (start cycle included), plus any mem-wait cycles. mdu_done arrives in cycle MDU_LAT+1 after start.
- Mem wait: stall for every non-ack cycle. An ack in the same cycle as mem_req gives no stall and no state change.
- Timeout fires on the MEM_TIMEOUT-th consecutive non-ack cycle.
- flush and bus_err are single-cycle pulses. flush together with mem_ack: flush wins and the ack is ignored.

## Structure
- Shared package/defines: stall vector encodings (STALL_NONE, STALL_ID=000111, STALL_EX=001111, STALL_MEM=011111), state encodings, ERR_VEC default.
- Single module. No sub-module: the counters are too small to justify one.

## Test plan
- id_stallreq high 2 cycles from RUN -> stall=000111 both cycles, then 000000; state stays RUN.
- ex_mdu_start pulse, MDU_LAT=32 -> stall=001111 for 32 cycles, mdu_done=1 and stall=0 on cycle 33.
- mem_req held, mem_ack after 3 wait cycles -> stall=011111 ×3, stall=0 on the ack cycle, back to RUN.
- Mem wait of 4 cycles inside MDU (start at t0, wait t5–t8) -> counter frozen during the wait; mdu_done at cycle 37.
- mem_req with no ack, MEM_TIMEOUT=64 -> bus_err=flush=1 and new_pc=BFC00380 on wait cycle 64, then RUN.
- flush_req with exc_pc=0x80000180 at MDU cycle 10 -> flush=1, new_pc=80000180, stall=0, never mdu_done. A separate run asserts rst at MDU cycle 5 -> all outputs 0 next cycle.
